pipe_tag_tracker: RTL
=====================

Name: pipe_tag_tracker

Overview:
- Synthesizable tag/valid tracker for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Assigns a sequence tag to every fetched instruction and moves tag+valid through the stages under stall, flush and halt control.
- Emits a per-stage tag/valid view and a retire strobe from WB.
- Sits directly upstream of the verification unit and replaces its ad-hoc id/valid bookkeeping; that unit indexes its message store by these tags.

Parameters:
- TAG_W, 7, tag width; tags wrap modulo 2^TAG_W.
- CNT_W, 32, width of cycle and retire counters.

Ports:
- clk  input  1  system clock, all state on posedge.
- rst_n  input  1  asynchronous active-low reset.
- stall  input  1  load-use/hazard stall: IF and ID hold, bubble into EX.
- flush  input  1  taken branch resolved in ID: squash instruction in IF.
- hlt_id  input  1  instruction currently in ID is HLT.
- if_valid, id_valid, ex_valid, mem_valid, wb_valid  output  1 each  stage holds a live instruction.
- if_tag, id_tag, ex_tag, mem_tag, wb_tag  output  TAG_W each  tag of the stage occupant.
- retire  output  1  equals wb_valid; WB instruction completes this cycle.
- retire_tag  output  TAG_W  equals wb_tag.
- inflight  output  3  count of asserted stage valids, 0..5.
- halted  output  1  HLT has retired; pipeline frozen.
- cycle_cnt  output  CNT_W  cycles since reset, frozen once halted.
- retired_cnt  output  CNT_W  number of retire cycles.

Behaviour:
- Reset (async, rst_n=0): all valids 0, all tags 0, next_tag 0, fetch_stop 0, per-stage hlt bits 0, halted 0, counters 0. Reset asserted mid-operation clears state immediately, with no clock edge required.
- Per-stage state: valid, tag, and a hlt marker for ID/EX/MEM/WB. Stage outputs are direct register outputs with no combinational path from inputs.
- Priority at each posedge: halted > stall > flush > normal.
- halted=1: no register changes except none; all outputs hold. Only reset leaves this state.
- Normal (stall=0, flush=0):
  - IF loads {valid=!fetch_stop, tag=next_tag}.
  - next_tag increments (wraps 2^TAG_W-1 -> 0) only when IF loads a valid entry.
  - ID<=IF, EX<=ID, MEM<=EX, WB<=MEM.
- stall=1:
  - IF and ID hold; next_tag holds.
  - EX loads a bubble (valid 0, hlt 0).
  - MEM<=EX, WB<=MEM.
  - A flush asserted together with stall is ignored. Upstream must re-assert flush after the stall.
- flush=1 (stall=0): as normal, except ID loads a bubble instead of the IF content. IF still loads a new tag, so the squashed tag is consumed and never retires.
- Halt:
  - When id_valid & hlt_id & !stall at a posedge, fetch_stop sets and the ID hlt bit travels to EX with the instruction.
  - On the same edge, ID loads a bubble (the instruction after HLT is squashed) and IF loads a bubble.
  - From then on, fetch_stop=1 keeps IF invalid.
- halted sets on the edge where WB is valid with its hlt bit set, i.e. one cycle after the HLT retire strobe.
- Counters:
  - cycle_cnt increments every edge while !halted.
  - retired_cnt increments on each edge where retire=1.
  - Both wrap at 2^CNT_W.
- inflight is the combinational popcount of the five valids.
- Latency: a tag fetched at edge N retires (retire=1) during cycle N+4 with no stalls, plus one cycle per stall cycle it spends in IF/ID.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- Defined: adds outputs stall_cnt and flush_cnt (CNT_W each).
  - Reset to 0.
  - Increment on each non-halted edge with stall=1 (stall_cnt), or with flush=1 & stall=0 (flush_cnt).
  - Frozen once halted.
- Not defined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset release, no stall/flush for 8 cycles -> if_tag 0..7 on successive edges; first retire with retire_tag=0 on the 5th cycle; inflight reaches 5; retired_cnt=4 after cycle 8.
- stall high for 2 cycles while tag 5 is in ID -> id_tag=5 and if_tag=6 held for 2 cycles; ex_valid=0 twice; tag 5 retires 2 cycles later than nominal; next_tag resumes at 7.
- flush for 1 cycle while tag 9 is in IF -> tag 9 never appears on retire_tag; retire sequence 8,10,11; one retire-bubble cycle.
- stall and flush together for 1 cycle -> behaves as pure stall, no tag squashed.
- Drive 126 instructions, then continue -> if_tag sequence 126,127,0,1; retire_tag wraps the same way.
- hlt_id with tag 20 in ID -> IF/ID go invalid, no new tags; retire_tag=20; halted=1 the next cycle; cycle_cnt and all outputs frozen for 10 further cycles; async rst_n pulse mid-freeze clears all outputs to 0.

Source files
------------

// File: rtl/pipe_tag_tracker.sv
// pipe_tag_tracker: gives each fetched instruction a sequence tag and carries
// tag, valid and a halt marker through the five pipeline stages
// (IF, ID, EX, MEM, WB) under stall, flush and halt control.
// Optional macro PIPE_PERF_CNT_EN adds the stall_cnt and flush_cnt counters.
module pipe_tag_tracker #(
  parameter int unsigned TAG_W = 7,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             hlt_id,
  output logic             if_valid,
  output logic             id_valid,
  output logic             ex_valid,
  output logic             mem_valid,
  output logic             wb_valid,
  output logic [TAG_W-1:0] if_tag,
  output logic [TAG_W-1:0] id_tag,
  output logic [TAG_W-1:0] ex_tag,
  output logic [TAG_W-1:0] mem_tag,
  output logic [TAG_W-1:0] wb_tag,
  output logic             retire,
  output logic [TAG_W-1:0] retire_tag,
  output logic [2:0]       inflight,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retired_cnt
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  logic             if_v_q, if_v_d;
  logic [TAG_W-1:0] if_tag_q, if_tag_d;
  logic             id_v_q, id_v_d;
  logic [TAG_W-1:0] id_tag_q, id_tag_d;
  logic             ex_v_q, ex_v_d;
  logic [TAG_W-1:0] ex_tag_q, ex_tag_d;
  logic             ex_hlt_q, ex_hlt_d;
  logic             mem_v_q, mem_v_d;
  logic [TAG_W-1:0] mem_tag_q, mem_tag_d;
  logic             mem_hlt_q, mem_hlt_d;
  logic             wb_v_q, wb_v_d;
  logic [TAG_W-1:0] wb_tag_q, wb_tag_d;
  logic             wb_hlt_q, wb_hlt_d;
  logic [TAG_W-1:0] next_tag_q, next_tag_d;
  logic             fetch_stop_q, fetch_stop_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] retired_cnt_q, retired_cnt_d;
  logic             halt_now;
`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
`endif

  // Next-state: halted freezes everything, else stall > flush > normal advance.
  always_comb begin
    if_v_d        = if_v_q;
    if_tag_d      = if_tag_q;
    id_v_d        = id_v_q;
    id_tag_d      = id_tag_q;
    ex_v_d        = ex_v_q;
    ex_tag_d      = ex_tag_q;
    ex_hlt_d      = ex_hlt_q;
    mem_v_d       = mem_v_q;
    mem_tag_d     = mem_tag_q;
    mem_hlt_d     = mem_hlt_q;
    wb_v_d        = wb_v_q;
    wb_tag_d      = wb_tag_q;
    wb_hlt_d      = wb_hlt_q;
    next_tag_d    = next_tag_q;
    fetch_stop_d  = fetch_stop_q;
    halted_d      = halted_q;
    cycle_cnt_d   = cycle_cnt_q;
    retired_cnt_d = retired_cnt_q;
    halt_now      = 1'b0;
`ifdef PIPE_PERF_CNT_EN
    stall_cnt_d   = stall_cnt_q;
    flush_cnt_d   = flush_cnt_q;
`endif

    if (!halted_q) begin
      cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
      if (wb_v_q) retired_cnt_d = retired_cnt_q + CNT_W'(1);
      if (wb_v_q && wb_hlt_q) halted_d = 1'b1;

      // Back end always advances.
      mem_v_d   = ex_v_q;
      mem_tag_d = ex_tag_q;
      mem_hlt_d = ex_hlt_q;
      wb_v_d    = mem_v_q;
      wb_tag_d  = mem_tag_q;
      wb_hlt_d  = mem_hlt_q;

      if (stall) begin
        // IF/ID hold, bubble into EX; a coincident flush is dropped.
        ex_v_d   = 1'b0;
        ex_tag_d = '0;
        ex_hlt_d = 1'b0;
`ifdef PIPE_PERF_CNT_EN
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
`endif
      end else begin
        halt_now = id_v_q & hlt_id;
        ex_v_d   = id_v_q;
        ex_tag_d = id_tag_q;
        ex_hlt_d = halt_now;

        if (halt_now || flush) begin
          id_v_d   = 1'b0;
          id_tag_d = '0;
        end else begin
          id_v_d   = if_v_q;
          id_tag_d = if_tag_q;
        end

        if (halt_now) begin
          fetch_stop_d = 1'b1;
          if_v_d       = 1'b0;
          if_tag_d     = next_tag_q;
        end else begin
          if_v_d   = !fetch_stop_q;
          if_tag_d = next_tag_q;
          if (!fetch_stop_q) next_tag_d = next_tag_q + TAG_W'(1);
        end
`ifdef PIPE_PERF_CNT_EN
        if (flush) flush_cnt_d = flush_cnt_q + CNT_W'(1);
`endif
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_v_q        <= 1'b0;
      if_tag_q      <= '0;
      id_v_q        <= 1'b0;
      id_tag_q      <= '0;
      ex_v_q        <= 1'b0;
      ex_tag_q      <= '0;
      ex_hlt_q      <= 1'b0;
      mem_v_q       <= 1'b0;
      mem_tag_q     <= '0;
      mem_hlt_q     <= 1'b0;
      wb_v_q        <= 1'b0;
      wb_tag_q      <= '0;
      wb_hlt_q      <= 1'b0;
      next_tag_q    <= '0;
      fetch_stop_q  <= 1'b0;
      halted_q      <= 1'b0;
      cycle_cnt_q   <= '0;
      retired_cnt_q <= '0;
`ifdef PIPE_PERF_CNT_EN
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
`endif
    end else begin
      if_v_q        <= if_v_d;
      if_tag_q      <= if_tag_d;
      id_v_q        <= id_v_d;
      id_tag_q      <= id_tag_d;
      ex_v_q        <= ex_v_d;
      ex_tag_q      <= ex_tag_d;
      ex_hlt_q      <= ex_hlt_d;
      mem_v_q       <= mem_v_d;
      mem_tag_q     <= mem_tag_d;
      mem_hlt_q     <= mem_hlt_d;
      wb_v_q        <= wb_v_d;
      wb_tag_q      <= wb_tag_d;
      wb_hlt_q      <= wb_hlt_d;
      next_tag_q    <= next_tag_d;
      fetch_stop_q  <= fetch_stop_d;
      halted_q      <= halted_d;
      cycle_cnt_q   <= cycle_cnt_d;
      retired_cnt_q <= retired_cnt_d;
`ifdef PIPE_PERF_CNT_EN
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
`endif
    end
  end

  // Stage view straight from registers; retire mirrors WB.
  assign if_valid    = if_v_q;
  assign id_valid    = id_v_q;
  assign ex_valid    = ex_v_q;
  assign mem_valid   = mem_v_q;
  assign wb_valid    = wb_v_q;
  assign if_tag      = if_tag_q;
  assign id_tag      = id_tag_q;
  assign ex_tag      = ex_tag_q;
  assign mem_tag     = mem_tag_q;
  assign wb_tag      = wb_tag_q;
  assign retire      = wb_v_q;
  assign retire_tag  = wb_tag_q;
  assign halted      = halted_q;
  assign cycle_cnt   = cycle_cnt_q;
  assign retired_cnt = retired_cnt_q;
  assign inflight    = 3'(if_v_q) + 3'(id_v_q) + 3'(ex_v_q) + 3'(mem_v_q) + 3'(wb_v_q);
`ifdef PIPE_PERF_CNT_EN
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;
`endif

endmodule
